// File: rtl/led_pattern_sched.sv
// Round-robin LED blink-code scheduler: requester i is granted and blinks i+1 pulses, then a gap.
// Optional idle heartbeat is enabled by defining LED_SCHED_HEARTBEAT_EN.
module led_pattern_sched #(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 2499999,
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 4,
    parameter int GAP_TICKS = 16,
    parameter int HB_TICKS  = 10
) (
    input  logic               fpga_clk_50,
    input  logic               hps_fpga_reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               LED
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t           state;
    logic [25:0]      presc;
    logic [31:0]      phase_cnt;
    logic [3:0]       pulses_left;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] winner;
    logic             tick;
    logic             phase_end;
    logic             rr_hit;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W:0]   rr_sum;
`ifdef LED_SCHED_HEARTBEAT_EN
    logic [31:0]      hb_cnt;
`endif

    assign tick      = (presc == 26'(TICK_DIV));
    assign phase_end = tick && (phase_cnt == 32'd1);

    // Scan from the highest offset down so the nearest requester after last_gnt wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        rr_sum = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            rr_sum = {1'b0, last_gnt} + (IDX_W+1)'(off);
            if (rr_sum >= (IDX_W+1)'(NUM_REQ))
                rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
            if (req[rr_sum[IDX_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = rr_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
        if (!hps_fpga_reset_n) begin
            state       <= IDLE;
            LED         <= 1'b0;
            grant       <= '0;
            done        <= '0;
            busy        <= 1'b0;
            presc       <= '0;
            phase_cnt   <= '0;
            pulses_left <= '0;
            last_gnt    <= IDX_W'(NUM_REQ-1);
            winner      <= '0;
`ifdef LED_SCHED_HEARTBEAT_EN
            hb_cnt      <= '0;
`endif
        end else begin
            done  <= '0;
            presc <= tick ? '0 : presc + 26'd1;
            case (state)
                IDLE: begin
                    if (rr_hit) begin
                        state       <= ON;
                        grant       <= NUM_REQ'(1) << rr_idx;
                        winner      <= rr_idx;
                        pulses_left <= 4'(rr_idx) + 4'd1;
                        phase_cnt   <= 32'(ON_TICKS);
                        presc       <= '0;
                        LED         <= 1'b1;
                        busy        <= 1'b1;
`ifdef LED_SCHED_HEARTBEAT_EN
                        hb_cnt      <= '0;
`endif
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
`ifdef LED_SCHED_HEARTBEAT_EN
                        if (tick) begin
                            if (hb_cnt == 32'(HB_TICKS-1)) begin
                                hb_cnt <= '0;
                                LED    <= ~LED;
                            end else begin
                                hb_cnt <= hb_cnt + 32'd1;
                            end
                        end
`else
                        LED <= 1'b0;
`endif
                    end
                end
                ON: begin
                    if (phase_end) begin
                        presc <= '0;
                        LED   <= 1'b0;
                        if (pulses_left > 4'd1) begin
                            pulses_left <= pulses_left - 4'd1;
                            phase_cnt   <= 32'(OFF_TICKS);
                            state       <= OFF;
                        end else begin
                            phase_cnt <= 32'(GAP_TICKS);
                            state     <= GAP;
                        end
                    end else if (tick) begin
                        phase_cnt <= phase_cnt - 32'd1;
                    end
                end
                OFF: begin
                    if (phase_end) begin
                        presc     <= '0;
                        LED       <= 1'b1;
                        phase_cnt <= 32'(ON_TICKS);
                        state     <= ON;
                    end else if (tick) begin
                        phase_cnt <= phase_cnt - 32'd1;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        presc       <= '0;
                        done        <= NUM_REQ'(1) << winner;
                        grant       <= '0;
                        busy        <= 1'b0;
                        LED         <= 1'b0;
                        last_gnt    <= winner;
                        phase_cnt   <= '0;
                        pulses_left <= '0;
                        state       <= IDLE;
                    end else if (tick) begin
                        phase_cnt <= phase_cnt - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/led_pattern_sched.md
LED_PATTERN_SCHED -- requirements
Module: led_pattern_sched

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters (2..8).
REQ-002 Parameter TICK_DIV, 2499999, prescaler terminal count; one tick = TICK_DIV+1 clocks (50 ms at 50 MHz).
REQ-003 Parameter ON_TICKS, 4, ticks LED is high per pulse (>=1).
REQ-004 Parameter OFF_TICKS, 4, ticks LED is low between pulses (>=1).
REQ-005 Parameter GAP_TICKS, 16, ticks LED is low after the last pulse (>=1).
REQ-006 Parameter HB_TICKS, 10, idle heartbeat half-period in ticks (>=1).
REQ-007 fpga_clk_50  input  1  system clock, 50 MHz.
REQ-008 hps_fpga_reset_n  input  1  asynchronous, active-low reset.
REQ-009 req  input  NUM_REQ  level requests; bit i asks for a code of i+1 pulses.
REQ-010 grant  output  NUM_REQ  one-hot, registered; bit set while that requester's code plays.
REQ-011 done  output  NUM_REQ  one-cycle pulse on the granted bit when its code completes.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 LED  output  1  registered LED drive.

Function
REQ-014 States: IDLE, ON, OFF, GAP; all outputs registered.
REQ-015 Prescaler: 26-bit counter 0..TICK_DIV; tick is one cycle when counter==TICK_DIV; counter clears to 0 on every state transition, so each phase lasts exactly N*(TICK_DIV+1) clocks.
REQ-016 Phase counter loads ON_TICKS/OFF_TICKS/GAP_TICKS on entry to ON/OFF/GAP, decrements on tick; phase ends on the tick where it equals 1.
REQ-017 IDLE: if any req bit set, select winner round-robin starting at index after last granted (wrap NUM_REQ-1 -> 0), set grant, load pulses_left = winner+1, enter ON next cycle (LED high one cycle after req is sampled).
REQ-018 ON: LED=1; at phase end go to OFF if pulses_left>1 (decrement pulses_left), else GAP.
REQ-019 OFF: LED=0; at phase end go to ON.
REQ-020 GAP: LED=0; at phase end pulse done[winner] for one cycle, clear grant, update last-granted, go to IDLE.
REQ-021 Requests are sampled only in IDLE; req deassertion or change mid-sequence does not abort or alter the code.
REQ-022 A requester holding req across done is re-eligible; round-robin rotation ensures every other asserted requester is served before it repeats.
REQ-023 Multiple simultaneous requests: exactly one grant; never more than one grant bit set.
REQ-024 IDLE with no request: grant=0, done=0, busy=0; LED per REQ-029/030.

Reset
REQ-025 On hps_fpga_reset_n low, immediately: state=IDLE, LED=0, grant=0, done=0, busy=0, prescaler=0, phase counter=0, pulses_left=0.
REQ-026 Last-granted resets to NUM_REQ-1 so req[0] wins first arbitration.
REQ-027 Reset mid-sequence aborts the code with no done pulse.
REQ-028 First arbitration occurs on the first clock edge after reset release.

Configuration
REQ-029 With LED_SCHED_HEARTBEAT_EN defined: in IDLE the prescaler free-runs and LED toggles every HB_TICKS ticks; heartbeat level and count clear to 0 on leaving IDLE and restart from LED=0 on return.
REQ-030 Without LED_SCHED_HEARTBEAT_EN: LED held 0 in IDLE; heartbeat logic absent.

Verification (TICK_DIV=3, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=4, HB_TICKS=2)
REQ-031 req=0001 one cycle -> grant=0001 next cycle, LED high 8 clocks, low 16 clocks, done[0] pulse, back to IDLE, busy low.
REQ-032 req=0100 held -> three 8-clock high pulses separated by 8 low clocks, 16-clock gap, done[2], then sequence repeats.
REQ-033 req=1111 held -> grants in order 0001,0010,0100,1000,0001; pulse counts 1,2,3,4,1.
REQ-034 req=0010 dropped after grant -> full two-pulse code still plays and done[1] fires.
REQ-035 Reset asserted during second ON of req[3] code -> all outputs 0 immediately, no done; after release with req=1000 held, code restarts with full 4 pulses.
REQ-036 Idle, heartbeat macro defined -> LED toggles every 8 clocks; undefined -> LED stays 0.
